bcd_code_encoder: RTL and testbench
===================================

// Module: bcd_code_encoder
// PURPOSE
// Streaming BCD-to-code encoder; inverse of the team's code-to-BCD converter (code bits {H,G,F,E}).
// Accepts one BCD digit per handshake, emits its 4-bit codeword registered, through a 2-entry skid stage.
// Flags or drops non-BCD input; counts digits sent and errors. Feeds the converter in loopback benches.
// PARAMETERS
// ERR_DROP  0  1: discard inputs 10..15 (no output beat); 0: emit code 4'b1111 with out_err=1
// CNT_W     8  width of digit_cnt and err_cnt
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      synchronous reset, active-high
// in_valid   in   1      in_bcd valid
// in_ready   out  1      encoder can accept in_bcd this cycle
// in_bcd     in   4      BCD digit, bit3 = MSB
// out_valid  out  1      out_code/out_err valid
// out_ready  in   1      downstream accepts this cycle
// out_code   out  4      codeword {H,G,F,E}: bit3=H, bit2=G, bit1=F, bit0=E
// out_err    out  1      beat carries an invalid-input marker (ERR_DROP=0 only)
// digit_cnt  out  CNT_W  valid digits delivered on output (out_valid & out_ready & !out_err)
// err_cnt    out  CNT_W  invalid inputs accepted (in_valid & in_ready & in_bcd>9)
// BEHAVIOUR
// - Code table (d -> {H,G,F,E}): 0:0000 1:0001 2:0011 3:0100 4:0101 5:0111 6:1001 7:1011 8:1100 9:1101
// - Input fire = in_valid & in_ready; output fire = out_valid & out_ready. Encoding done at accept.
// - Storage: out register (head) + skid register. FSM on occupancy:
//   EMPTY: in fire -> ONE (head loaded). in_ready=1, out_valid=0.
//   ONE:   in fire & out fire -> ONE (head replaced); in fire only -> TWO (skid loaded);
//          out fire only -> EMPTY. in_ready=1, out_valid=1.
//   TWO:   in_ready=0; out fire -> ONE, skid moves to head same edge. out_valid=1.
// - Latency: accepted digit appears on out_code next cycle when FSM was EMPTY, or ONE with out fire.
// - in_ready depends only on state (no combinational path from out_ready).
// - Order strictly preserved; no beat duplicated or lost except ERR_DROP=1 drops.
// - ERR_DROP=1 & in_bcd>9: in_ready still as per state, digit consumed, no storage write, state unchanged
//   (except an out fire in that cycle), err_cnt++.
// - ERR_DROP=0 & in_bcd>9: stored as code 4'b1111, out_err=1, err_cnt++ at accept.
// - out_code/out_err held stable while out_valid & !out_ready.
// - Counters wrap modulo 2^CNT_W; both may increment in the same cycle.
// - Reset (any cycle, incl. mid-transfer): state EMPTY, out_valid=0, out_code=0000, out_err=0,
//   digit_cnt=0, err_cnt=0, skid cleared; in_ready=1 the cycle after rst deasserts. In-flight data lost.
// - Reset has priority over simultaneous in/out fire.
// TESTING
// 1 Sweep 0..9, out_ready=1 -> codes 0000,0001,0011,0100,0101,0111,1001,1011,1100,1101, 1-cycle latency, digit_cnt=10.
// 2 out_ready=0, send 3 then 7 -> in_ready=0 after 2nd accept, out_code holds 0100; release -> 0100 then 1011.
// 3 ERR_DROP=0, send 12 -> out_code=1111, out_err=1, err_cnt=1, digit_cnt unchanged on its fire.
// 4 ERR_DROP=1, send 5,14,9 -> outputs 0111,1101 only, err_cnt=1, digit_cnt=2.
// 5 rst pulsed while TWO -> next cycle out_valid=0, in_ready=1, counters 0, no stale beat emitted.
// 6 Random valid/ready, 1000 digits, loopback into code-to-BCD converter -> recovered digits equal inputs, in order.

Source files
------------

// File: rtl/bcd_code_encoder.sv
//============================================================================
// Module   : bcd_code_encoder
// Brief    : Streaming BCD-to-{H,G,F,E} code encoder behind a 2-entry skid
//            stage, with invalid-digit flagging/dropping and beat counters.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module bcd_code_encoder #(
    parameter bit ERR_DROP = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_bcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_code,
    output logic             out_err,
    output logic [CNT_W-1:0] digit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_head_code;
    logic             r_head_err;
    logic [3:0]       r_skid_code;
    logic             r_skid_err;
    logic [CNT_W-1:0] r_digit_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_bad;
    logic       w_store;
    logic [3:0] w_code;
    logic       w_load_head;
    logic       w_load_skid;
    logic       w_move_skid;

    assign w_bad      = (in_bcd > 4'd9);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    // A dropped invalid digit is consumed without touching storage or state.
    assign w_store    = w_in_fire & ~(ERR_DROP & w_bad);

    always_comb begin
        w_code = 4'b1111;
        case (in_bcd)
            4'd0:    w_code = 4'b0000;
            4'd1:    w_code = 4'b0001;
            4'd2:    w_code = 4'b0011;
            4'd3:    w_code = 4'b0100;
            4'd4:    w_code = 4'b0101;
            4'd5:    w_code = 4'b0111;
            4'd6:    w_code = 4'b1001;
            4'd7:    w_code = 4'b1011;
            4'd8:    w_code = 4'b1100;
            4'd9:    w_code = 4'b1101;
            default: w_code = 4'b1111;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        in_ready    = 1'b1;
        out_valid   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_store) begin
                    w_load_head = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                out_valid = 1'b1;
                if (w_store && w_out_fire) begin
                    w_load_head = 1'b1;
                end else if (w_store) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (w_out_fire) begin
                    w_move_skid = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_head_code <= 4'b0000;
            r_head_err  <= 1'b0;
            r_skid_code <= 4'b0000;
            r_skid_err  <= 1'b0;
            r_digit_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_head) begin
                r_head_code <= w_code;
                r_head_err  <= w_bad;
            end else if (w_move_skid) begin
                r_head_code <= r_skid_code;
                r_head_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_code <= w_code;
                r_skid_err  <= w_bad;
            end
            if (w_out_fire && !r_head_err) begin
                r_digit_cnt <= r_digit_cnt + c_CNT_ONE;
            end
            if (w_in_fire && w_bad) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign out_code  = r_head_code;
    assign out_err   = r_head_err;
    assign digit_cnt = r_digit_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bcd_code_encoder.sv
//============================================================================
// Module   : tb_bcd_code_encoder
// Brief    : Bench for bcd_code_encoder; instance 0 flags bad digits,
//            instance 1 drops them.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bcd_code_encoder;

    localparam int CNT_W = 8;
    localparam logic [3:0] c_tbl [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
                                          4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101};

    typedef struct {
        logic [3:0] bcd;
        logic [3:0] code;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [3:0]       in_bcd    [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic [3:0]       out_code  [2];
    logic             out_err   [2];
    logic [CNT_W-1:0] digit_cnt [2];
    logic [CNT_W-1:0] err_cnt   [2];

    int checks   = 0;
    int failures = 0;
    bit rnd      = 1'b0;

    int               exp_q  [2][$];
    logic [CNT_W-1:0] m_dcnt [2];
    logic [CNT_W-1:0] m_ecnt [2];
    bit               hold   [2];
    logic [3:0]       hold_code [2];
    logic             hold_err  [2];

    always #5 clk = ~clk;

    bcd_code_encoder #(.ERR_DROP(1'b0), .CNT_W(CNT_W)) u_dut_flag (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bcd(in_bcd[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_code(out_code[0]), .out_err(out_err[0]),
        .digit_cnt(digit_cnt[0]), .err_cnt(err_cnt[0])
    );

    bcd_code_encoder #(.ERR_DROP(1'b1), .CNT_W(CNT_W)) u_dut_drop (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bcd(in_bcd[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_code(out_code[1]), .out_err(out_err[1]),
        .digit_cnt(digit_cnt[1]), .err_cnt(err_cnt[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Code-to-BCD converter: inverse lookup of the code table.
    function automatic int decode(input logic [3:0] c);
        for (int i = 0; i < 10; i++) begin
            if (c_tbl[i] == c) return i;
        end
        return -1;
    endfunction

    // Scoreboard: queue of accepted digits, decoded back from the output beats.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_q[k].delete();
                m_dcnt[k] = '0;
                m_ecnt[k] = '0;
                hold[k]   = 1'b0;
            end else begin
                chk("digit_cnt", int'(digit_cnt[k]), int'(m_dcnt[k]));
                chk("err_cnt", int'(err_cnt[k]), int'(m_ecnt[k]));
                if (hold[k]) begin
                    chk("hold_valid", int'(out_valid[k]), 1);
                    chk("hold_code", int'(out_code[k]), int'(hold_code[k]));
                    chk("hold_err", int'(out_err[k]), int'(hold_err[k]));
                end
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_beat", int'(out_code[k]), -1);
                    end else begin
                        int d;
                        d = exp_q[k].pop_front();
                        if (d > 9) begin
                            chk("err_beat_code", int'(out_code[k]), 15);
                            chk("err_beat_flag", int'(out_err[k]), 1);
                        end else begin
                            chk("loopback_digit", decode(out_code[k]), d);
                            chk("beat_flag", int'(out_err[k]), 0);
                            m_dcnt[k] = m_dcnt[k] + 1'b1;
                        end
                    end
                end
                if (in_valid[k] && in_ready[k]) begin
                    if (in_bcd[k] > 4'd9) m_ecnt[k] = m_ecnt[k] + 1'b1;
                    if (!(k == 1 && in_bcd[k] > 4'd9)) exp_q[k].push_back(int'(in_bcd[k]));
                end
                hold[k]      = out_valid[k] && !out_ready[k];
                hold_code[k] = out_code[k];
                hold_err[k]  = out_err[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            in_bcd[k]   = 4'd0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input int k, input logic [3:0] d);
        bit done;
        done        = 1'b0;
        in_valid[k] = 1'b1;
        in_bcd[k]   = d;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready[k]) done = 1'b1;
            step();
            if (rnd) out_ready[k] = ($urandom_range(0, 3) != 0);
        end
        in_valid[k] = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic random_run(input int k, input int n);
        int n_ok;
        int n_bad;
        logic [3:0] d;
        n_ok  = 0;
        n_bad = 0;
        do_reset();
        rnd = 1'b1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(10, 15));
            else                           d = 4'($urandom_range(0, 9));
            if (d > 4'd9) n_bad++; else n_ok++;
            if ($urandom_range(0, 3) == 0) begin
                step();
                out_ready[k] = ($urandom_range(0, 3) != 0);
            end
            send(k, d);
        end
        rnd          = 1'b0;
        out_ready[k] = 1'b1;
        for (int t = 0; t < 20 && exp_q[k].size() != 0; t++) step();
        step();
        chk("drain_empty", exp_q[k].size(), 0);
        chk("final_digit_cnt", int'(digit_cnt[k]), n_ok % 256);
        chk("final_err_cnt", int'(err_cnt[k]), n_bad % 256);
    endtask

    initial begin
        vec_t vecs [10];
        logic [CNT_W-1:0] dsave;
        vecs[0] = '{4'd0, 4'b0000};
        vecs[1] = '{4'd1, 4'b0001};
        vecs[2] = '{4'd2, 4'b0011};
        vecs[3] = '{4'd3, 4'b0100};
        vecs[4] = '{4'd4, 4'b0101};
        vecs[5] = '{4'd5, 4'b0111};
        vecs[6] = '{4'd6, 4'b1001};
        vecs[7] = '{4'd7, 4'b1011};
        vecs[8] = '{4'd8, 4'b1100};
        vecs[9] = '{4'd9, 4'b1101};
        out_ready[0] = 1'b0;
        out_ready[1] = 1'b0;
        do_reset();

        chk("rst_out_valid", int'(out_valid[0]), 0);
        chk("rst_in_ready", int'(in_ready[0]), 1);
        chk("rst_out_code", int'(out_code[0]), 0);
        chk("rst_out_err", int'(out_err[0]), 0);

        // Full sweep, one-cycle latency with downstream always ready.
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(0, vecs[i].bcd);
            chk("sweep_valid", int'(out_valid[0]), 1);
            chk("sweep_code", int'(out_code[0]), int'(vecs[i].code));
        end
        step();
        chk("sweep_digit_cnt", int'(digit_cnt[0]), 10);
        chk("sweep_drained", int'(out_valid[0]), 0);

        // Backpressure fills the skid stage.
        do_reset();
        out_ready[0] = 1'b0;
        send(0, 4'd3);
        send(0, 4'd7);
        chk("bp_in_ready", int'(in_ready[0]), 0);
        chk("bp_head", int'(out_code[0]), 4'b0100);
        step();
        chk("bp_head_held", int'(out_code[0]), 4'b0100);
        out_ready[0] = 1'b1;
        step();
        chk("bp_second", int'(out_code[0]), 4'b1011);
        chk("bp_ready_back", int'(in_ready[0]), 1);
        step();
        chk("bp_empty", int'(out_valid[0]), 0);

        // Invalid digit flagged.
        do_reset();
        out_ready[0] = 1'b1;
        send(0, 4'd12);
        chk("flag_code", int'(out_code[0]), 4'b1111);
        chk("flag_err", int'(out_err[0]), 1);
        chk("flag_err_cnt", int'(err_cnt[0]), 1);
        dsave = digit_cnt[0];
        step();
        chk("flag_digit_cnt", int'(digit_cnt[0]), int'(dsave));

        // Invalid digit dropped.
        do_reset();
        out_ready[1] = 1'b1;
        send(1, 4'd5);
        chk("drop_first", int'(out_code[1]), 4'b0111);
        send(1, 4'd14);
        chk("drop_no_beat", int'(out_valid[1]), 0);
        send(1, 4'd9);
        chk("drop_second", int'(out_code[1]), 4'b1101);
        step();
        chk("drop_err_cnt", int'(err_cnt[1]), 1);
        chk("drop_digit_cnt", int'(digit_cnt[1]), 2);

        // Reset while full, coinciding with both handshakes.
        do_reset();
        out_ready[0] = 1'b0;
        send(0, 4'd1);
        send(0, 4'd2);
        chk("full_in_ready", int'(in_ready[0]), 0);
        rst          = 1'b1;
        in_valid[0]  = 1'b1;
        in_bcd[0]    = 4'd4;
        out_ready[0] = 1'b1;
        step();
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        chk("mrst_out_valid", int'(out_valid[0]), 0);
        chk("mrst_in_ready", int'(in_ready[0]), 1);
        chk("mrst_digit_cnt", int'(digit_cnt[0]), 0);
        chk("mrst_err_cnt", int'(err_cnt[0]), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_no_stale", int'(out_valid[0]), 0);
        end

        random_run(0, 1000);
        random_run(1, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
